temporizador_descendente: RTL and testbench

TEMPORIZADOR_DESCENDENTE -- requirements
Module: temporizador_descendente

---
 rtl/temporizador_descendente_if.sv | 23 ++
 rtl/temporizador_descendente.sv | 105 ++++++++++
 tb/tb_temporizador_descendente.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/temporizador_descendente_if.sv
// Control/status bundle for temporizador_descendente: the start/stop/en/load_val
// request side and the count/busy/done status side.
interface temporizador_descendente_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             stop;
  logic             en;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;

  modport master (
    output start, stop, en, load_val,
    input  count, busy, done
  );

  modport slave (
    input  start, stop, en, load_val,
    output count, busy, done
  );
endinterface

// File: rtl/temporizador_descendente.sv
// Down-counting timer with IDLE/RUN/DONE Moore FSM.
// Loads load_val on start, decrements once per cycle with en high, and
// flags done for the cycle in which the count reaches zero.
// Optional feature: define TEMPORIZADOR_AUTO_RELOAD_EN to reload from
// load_val after DONE instead of returning to IDLE (periodic done pulse).
module temporizador_descendente #(
  parameter int WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  temporizador_descendente_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Next-state and next-count decode; busy/done follow the next state so the
  // registered flags always match the state register.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        // start wins over a simultaneous stop here; stop only matters later
        if (bus.start) begin
          if (bus.load_val == ZERO) begin
            state_d = DONE;
            count_d = ZERO;
          end else begin
            state_d = RUN;
            count_d = bus.load_val;
          end
        end
      end
      RUN: begin
        if (bus.stop) begin
          state_d = IDLE;
        end else if (bus.en) begin
          // count <= 1 covers the terminal tick and guards against any wrap
          if (count_q <= ONE) begin
            state_d = DONE;
            count_d = ZERO;
          end else begin
            count_d = count_q - ONE;
          end
        end
      end
      DONE: begin
        if (bus.stop) begin
          state_d = IDLE;
        end else begin
`ifdef TEMPORIZADOR_AUTO_RELOAD_EN
          if (bus.load_val == ZERO) begin
            state_d = DONE;
            count_d = ZERO;
          end else begin
            state_d = RUN;
            count_d = bus.load_val;
          end
`else
          state_d = IDLE;
          count_d = ZERO;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        count_d = ZERO;
      end
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // State, count and status registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= ZERO;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.count = count_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_temporizador_descendente.sv
// Directed bench for temporizador_descendente (WIDTH=8), covering both
// builds of TEMPORIZADOR_AUTO_RELOAD_EN.
module tb_temporizador_descendente;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  temporizador_descendente_if #(.WIDTH(8)) bus ();

  temporizador_descendente #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  // advance one rising edge and settle before sampling
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_st(input string tag, input logic [7:0] c, input logic b, input logic d);
    chk({tag, ".count"}, 32'(bus.count), 32'(c));
    chk({tag, ".busy"},  32'(bus.busy),  32'(b));
    chk({tag, ".done"},  32'(bus.done),  32'(d));
  endtask

  // leave DONE and land in IDLE with count 0 in either build
  task automatic leave_done(input string tag);
`ifdef TEMPORIZADOR_AUTO_RELOAD_EN
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
`else
    tick();
`endif
    chk_st(tag, 8'd0, 1'b0, 1'b0);
  endtask

  logic [7:0] exp_cnt [7];

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.en = 1'b0;
    bus.load_val = 8'd0;

    // reset state
    tick();
    tick();
    chk_st("reset", 8'd0, 1'b0, 1'b0);
    rst = 1'b0;

    // load 5, en high: 5,4,3,2,1 then done with 0
    bus.load_val = 8'd5;
    bus.start = 1'b1;
    bus.en = 1'b1;
    tick();
    bus.start = 1'b0;
    chk_st("l5_c5", 8'd5, 1'b1, 1'b0);
    for (int k = 4; k >= 1; k--) begin
      tick();
      chk_st($sformatf("l5_c%0d", k), 8'(k), 1'b1, 1'b0);
    end
    tick();
    chk_st("l5_done", 8'd0, 1'b0, 1'b1);
    leave_done("l5_after");

    // load 4, en toggling; start (with a different load_val) ignored in RUN
    exp_cnt = '{8'd3, 8'd3, 8'd2, 8'd2, 8'd1, 8'd1, 8'd0};
    bus.load_val = 8'd4;
    bus.start = 1'b1;
    tick();
    chk_st("tog_load", 8'd4, 1'b1, 1'b0);
    bus.load_val = 8'd9;
    for (int i = 0; i < 7; i++) begin
      bus.en = (i % 2 == 0);
      bus.start = (i < 6);
      tick();
      chk_st($sformatf("tog_%0d", i), exp_cnt[i], (i < 6), (i == 6));
    end
    bus.start = 1'b0;
    bus.load_val = 8'd4;
    bus.en = 1'b1;
    leave_done("tog_after");

    // load 10, stop at count 7, then no further decrement in IDLE
    bus.load_val = 8'd10;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    tick();
    chk_st("stop_pre", 8'd7, 1'b1, 1'b0);
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    chk_st("stop_idle", 8'd7, 1'b0, 1'b0);
    tick();
    tick();
    chk_st("stop_hold", 8'd7, 1'b0, 1'b0);

    // start and stop together in IDLE act as start
    bus.load_val = 8'd2;
    bus.start = 1'b1;
    bus.stop = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.stop = 1'b0;
    chk_st("ss_load", 8'd2, 1'b1, 1'b0);
    tick();
    chk_st("ss_c1", 8'd1, 1'b1, 1'b0);
    tick();
    chk_st("ss_done", 8'd0, 1'b0, 1'b1);
    leave_done("ss_after");

    // load 0: straight to DONE
    bus.load_val = 8'd0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk_st("z_done", 8'd0, 1'b0, 1'b1);
`ifdef TEMPORIZADOR_AUTO_RELOAD_EN
    tick();
    chk_st("z_stay", 8'd0, 1'b0, 1'b1);
    leave_done("z_after");
`else
    tick();
    chk_st("z_after", 8'd0, 1'b0, 1'b0);
`endif

    // reset mid-count, then start right after reset release
    bus.load_val = 8'd3;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk_st("r_load", 8'd3, 1'b1, 1'b0);
    tick();
    chk_st("r_c2", 8'd2, 1'b1, 1'b0);
    rst = 1'b1;
    tick();
    chk_st("r_abort", 8'd0, 1'b0, 1'b0);
    rst = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk_st("r_restart", 8'd3, 1'b1, 1'b0);
    // reset overrides a simultaneous start
    rst = 1'b1;
    bus.start = 1'b1;
    tick();
    rst = 1'b0;
    bus.start = 1'b0;
    chk_st("r_override", 8'd0, 1'b0, 1'b0);

    // full-scale load value
    bus.load_val = 8'hFF;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk_st("max_load", 8'd255, 1'b1, 1'b0);
    tick();
    chk_st("max_dec", 8'd254, 1'b1, 1'b0);
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    chk_st("max_stop", 8'd254, 1'b0, 1'b0);

`ifdef TEMPORIZADOR_AUTO_RELOAD_EN
    // periodic done: 2,1,0,2,1,0 then stop in DONE
    bus.load_val = 8'd2;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int p = 0; p < 6; p++) begin
      chk_st($sformatf("ar_%0d", p), 8'(2 - (p % 3)), (p % 3 != 2), (p % 3 == 2));
      if (p < 5) tick();
    end
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    chk_st("ar_stop", 8'd0, 1'b0, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
